// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master memory/peripheral bus arbiter with address decode and wait states (option: ARB_FIXED_PRIO_EN)
module mem_bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int GPIO_DIR_ADDR = 254,
    parameter int GPIO_RW_ADDR  = 255,
    parameter int WAIT_STATES   = 0
) (
    input  logic              clock,
    input  logic              reset,
    // master 0 (CPU datapath)
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_ram,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    // master 1 (DMA / debug loader)
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_ram,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    // shared downstream bus
    output logic              bus_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_size,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              ram_cs,
    output logic              rom_cs,
    output logic              gpio_dir_ld,
    output logic              gpio_rw_sel
);

    localparam logic [ADDR_W-1:0] DIR_ADDR  = ADDR_W'(GPIO_DIR_ADDR);
    localparam logic [ADDR_W-1:0] RW_ADDR   = ADDR_W'(GPIO_RW_ADDR);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Transaction registers, loaded once per grant and held until the next grant
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Select decode is resolved at grant time so ACCESS cycles only replay flops
    logic              sel_dir_q;
    logic              sel_rw_q;
    logic              sel_ram_q;
    logic              sel_rom_q;
    logic              rom_wr_q;

    // Winner selection and its request fields
    logic              any_req;
    logic              winner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [1:0]        win_size;
    logic              win_we;
    logic              win_ram;
    logic              win_dir;
    logic              win_rw;
    logic              win_mem;

    assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    // m0 always takes a tie; m1 only wins when m0 is silent
    assign winner = ~m0_req;
`else
    // 1 = m1 had the most recent grant, so m0 wins the next tie
    logic rr_ptr;

    assign winner = (m0_req & m1_req) ? ~rr_ptr : ~m0_req;

    // Round-robin pointer remembers the last master granted
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            rr_ptr <= winner;
        end
    end
`endif

    assign win_addr  = winner ? m1_addr  : m0_addr;
    assign win_wdata = winner ? m1_wdata : m0_wdata;
    assign win_size  = winner ? m1_size  : m0_size;
    assign win_we    = winner ? m1_we    : m0_we;
    assign win_ram   = winner ? m1_ram   : m0_ram;

    // GPIO addresses take priority over the RAM/ROM space bit
    assign win_dir = (win_addr == DIR_ADDR);
    assign win_rw  = !win_dir && (win_addr == RW_ADDR);
    assign win_mem = !win_dir && !win_rw;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch winner fields on grant, count wait states, capture read data on the last ACCESS cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            owner     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            sel_dir_q <= 1'b0;
            sel_rw_q  <= 1'b0;
            sel_ram_q <= 1'b0;
            sel_rom_q <= 1'b0;
            rom_wr_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        addr_q    <= win_addr;
                        wdata_q   <= win_wdata;
                        size_q    <= win_size;
                        we_q      <= win_we;
                        wait_cnt  <= WAIT_INIT;
                        sel_dir_q <= win_dir;
                        sel_rw_q  <= win_rw;
                        sel_ram_q <= win_mem && win_ram;
                        // a write into ROM space selects nothing and is flagged instead
                        sel_rom_q <= win_mem && !win_ram && !win_we;
                        rom_wr_q  <= win_mem && !win_ram && win_we;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (!we_q) begin
                        if (owner) begin
                            rdata1_q <= bus_rdata;
                        end else begin
                            rdata0_q <= bus_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and bus strobes; selects only ever assert during ACCESS
    always_comb begin
        state_next  = state;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_done     = 1'b0;
        m1_done     = 1'b0;
        bus_err     = 1'b0;
        bus_we      = 1'b0;
        bus_re      = 1'b0;
        ram_cs      = 1'b0;
        rom_cs      = 1'b0;
        gpio_dir_ld = 1'b0;
        gpio_rw_sel = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                m0_gnt      = !owner;
                m1_gnt      = owner;
                ram_cs      = sel_ram_q;
                rom_cs      = sel_rom_q;
                gpio_dir_ld = sel_dir_q;
                gpio_rw_sel = sel_rw_q;
                bus_we      = we_q && !rom_wr_q;
                bus_re      = !we_q;
                if (wait_cnt == 4'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                m0_gnt     = !owner;
                m1_gnt     = owner;
                m0_done    = !owner;
                m1_done    = owner;
                bus_err    = rom_wr_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_size  = size_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
